// File: rtl/action_ctrl_multi.sv
// Multi-player button-to-action controller: one Moore FSM per player with timed jump,
// double-jump and cooldown phases. Optional macro ACTION_CTRL_EVENT_EN adds action_evt.
module action_ctrl_multi #(
  parameter int NUM_PLAYERS  = 2,
  parameter int JUMP_LEN     = 4,
  parameter int DOUBLE_LEN   = 2,
  parameter int COOLDOWN_LEN = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3*NUM_PLAYERS-1:0]   buttons,
  output logic [2*NUM_PLAYERS-1:0]   action,
`ifdef ACTION_CTRL_EVENT_EN
  output logic [NUM_PLAYERS-1:0]     action_evt,
`endif
  output logic [NUM_PLAYERS-1:0]     cooldown
);

  function automatic int max_len(input int a, input int b, input int c);
    int m;
    m = 2;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int CNT_W = $clog2(max_len(JUMP_LEN, DOUBLE_LEN, COOLDOWN_LEN));
  localparam logic [CNT_W-1:0] LAST_J = CNT_W'(JUMP_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DOUBLE_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(COOLDOWN_LEN - 1);

  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_RUN    = 3'd1,
    ST_JUMP   = 3'd2,
    ST_DOUBLE = 3'd3,
    ST_COOL   = 3'd4
  } state_t;

  function automatic logic [1:0] action_code(input state_t s);
    case (s)
      ST_RUN:    return 2'b11;
      ST_JUMP:   return 2'b01;
      ST_DOUBLE: return 2'b10;
      default:   return 2'b00;
    endcase
  endfunction

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             jprev_q;
    logic             jump, run, modi, jedge;

    assign jump  = buttons[3*p+2];
    assign run   = buttons[3*p+1];
    assign modi  = buttons[3*p];
    assign jedge = jump & ~jprev_q;

    // jprev resets high so a jump held through reset needs a fresh press
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_STAND;
        cnt_q   <= '0;
        jprev_q <= 1'b1;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        jprev_q <= jump;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_STAND: begin
          if (jedge) begin
            state_d = ST_JUMP;
            cnt_d   = '0;
          end else if (run) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (jedge) begin
            state_d = ST_JUMP;
            cnt_d   = '0;
          end else if (!run) begin
            state_d = ST_STAND;
          end
        end
        ST_JUMP: begin
          if (jedge && modi) begin
            state_d = ST_DOUBLE;
            cnt_d   = '0;
          end else if (cnt_q == LAST_J) begin
            state_d = run ? ST_RUN : ST_STAND;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DOUBLE: begin
          if (cnt_q == LAST_D) begin
            if (COOLDOWN_LEN == 0) state_d = run ? ST_RUN : ST_STAND;
            else                   state_d = ST_COOL;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_COOL: begin
          if (cnt_q == LAST_C) begin
            state_d = run ? ST_RUN : ST_STAND;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_STAND;
          cnt_d   = '0;
        end
      endcase
    end

    assign action[2*p +: 2] = action_code(state_q);
    assign cooldown[p]      = (state_q == ST_COOL);

`ifdef ACTION_CTRL_EVENT_EN
    logic evt_q;

    always_ff @(posedge clk) begin
      if (reset) evt_q <= 1'b0;
      else       evt_q <= (action_code(state_d) != action_code(state_q));
    end

    assign action_evt[p] = evt_q;
`endif
  end

endmodule
